// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, word RAM with byte enables,
// LED toggle register and free-running cycle counter, fixed wait-state latency.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] TOGGLE_ADDR = 32'd52,
   parameter logic [31:0] CYCLE_ADDR  = 32'd56
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] toggle_value
);

   localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam logic [2:0]  WS        = 3'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [2:0]  wcnt;
   logic        lat_we;
   logic [3:0]  lat_be;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] cycle_count;
   logic [31:0] mem [DEPTH_WORDS];

   logic             handshake;
   logic             commit;
   logic             acc_we;
   logic [3:0]       acc_be;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic             misaligned;
   logic             hit_toggle;
   logic             hit_cycle;
   logic             hit_ram;
   logic [IDX_W-1:0] idx;
   logic [31:0]      ram_word;
   logic [31:0]      next_rdata;
   logic             next_err;
   logic [31:0]      toggle_merged;
   logic             ram_wr;

   // With zero wait states the access commits on the handshake edge itself,
   // so the request fields come straight from the port instead of the latch.
   always_comb begin
      handshake = req_valid && req_ready;
      if (state == IDLE) begin
         acc_we    = req_we;
         acc_be    = req_be;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         commit    = handshake && (WS == 3'd0) && !reset;
      end else begin
         acc_we    = lat_we;
         acc_be    = lat_be;
         acc_addr  = lat_addr;
         acc_wdata = lat_wdata;
         // counter reaching zero on this edge is the commit point
         commit    = (state == WAIT) && (wcnt == 3'd1) && !reset;
      end
   end

   always_comb begin
      misaligned = acc_addr[1:0] != 2'b00;
      hit_toggle = !misaligned && (acc_addr == TOGGLE_ADDR);
      hit_cycle  = !misaligned && !hit_toggle && (acc_addr == CYCLE_ADDR);
      hit_ram    = !misaligned && !hit_toggle && !hit_cycle && ({1'b0, acc_addr} < RAM_BYTES);
      idx        = acc_addr[IDX_W+1:2];
      ram_word   = mem[idx];
      next_err   = 1'b1;
      next_rdata = '0;
      if (hit_toggle) begin
         next_err   = 1'b0;
         next_rdata = acc_we ? '0 : toggle_value;
      end else if (hit_cycle) begin
         next_err   = acc_we;
         next_rdata = acc_we ? '0 : cycle_count;
      end else if (hit_ram) begin
         next_err   = 1'b0;
         next_rdata = acc_we ? '0 : ram_word;
      end
      toggle_merged = toggle_value;
      for (int unsigned b = 0; b < 4; b++) begin
         if (acc_be[b]) toggle_merged[8*b +: 8] = acc_wdata[8*b +: 8];
      end
      ram_wr = commit && hit_ram && acc_we;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         wcnt         <= '0;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         toggle_value <= '0;
         cycle_count  <= '0;
         lat_we       <= 1'b0;
         lat_be       <= '0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (commit) begin
            rsp_rdata <= next_rdata;
            rsp_err   <= next_err;
            if (hit_toggle && acc_we) toggle_value <= toggle_merged;
         end
         case (state)
            IDLE: begin
               if (handshake) begin
                  lat_we    <= req_we;
                  lat_be    <= req_be;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  req_ready <= 1'b0;
                  if (WS == 3'd0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state <= WAIT;
                     wcnt  <= WS;
                  end
               end
            end
            WAIT: begin
               if (wcnt == 3'd1) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end
               wcnt <= wcnt - 3'd1;
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   // RAM has no reset; writes are gated by commit, which reset forces low.
   always_ff @(posedge clk) begin
      if (ram_wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (acc_be[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 0 and 7 wait states.
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic        req_valid    [3];
   logic        req_ready    [3];
   logic        req_we       [3];
   logic [3:0]  req_be       [3];
   logic [31:0] req_addr     [3];
   logic [31:0] req_wdata    [3];
   logic        rsp_valid    [3];
   logic [31:0] rsp_rdata    [3];
   logic        rsp_err      [3];
   logic [31:0] toggle_value [3];

   int n_vec;
   int n_bad;
   int cyc;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
      .toggle_value(toggle_value[0]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
      .toggle_value(toggle_value[1]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(7)) dut_c (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
      .req_be(req_be[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
      .toggle_value(toggle_value[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction; returns data, error, latency (edges from handshake
   // edge to the sample showing rsp_valid) and the tb cycle of the response.
   task automatic txn(input int d, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err,
                      output int lat, output int rcyc);
      int n;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_be[d]    = be;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[d]) check_eq("handshake_timeout", 32'(req_ready[d]), 32'd1);
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_we[d]    = ~we;
      req_be[d]    = ~be;
      req_addr[d]  = 32'hFFFF_FFF3;
      req_wdata[d] = 32'h5A5A_5A5A;
      lat = 1;
      while (!rsp_valid[d] && lat < 20) begin
         check_eq("ready_in_wait", 32'(req_ready[d]), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      if (!rsp_valid[d]) check_eq("rsp_timeout", 32'(rsp_valid[d]), 32'd1);
      check_eq("ready_in_resp", 32'(req_ready[d]), 32'd0);
      rdata = rsp_rdata[d];
      err   = rsp_err[d];
      rcyc  = cyc;
      @(posedge clk);
      #1;
      check_eq("rsp_one_cycle", 32'(rsp_valid[d]), 32'd0);
      check_eq("ready_after_resp", 32'(req_ready[d]), 32'd1);
      check_eq("rdata_hold", rsp_rdata[d], rdata);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"},  32'(req_ready[0]), 32'd1);
      check_eq({tag, "_valid"},  32'(rsp_valid[0]), 32'd0);
      check_eq({tag, "_rdata"},  rsp_rdata[0],      32'd0);
      check_eq({tag, "_err"},    32'(rsp_err[0]),   32'd0);
      check_eq({tag, "_toggle"}, toggle_value[0],   32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          rc;
      int          rc_prev;

      n_vec = 0;
      n_bad = 0;
      cyc   = 0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_be[i]    = '0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Counter is 0 out of reset: handshake on 2nd edge, commit on 3rd -> 2
      txn(0, 1'b0, 4'h0, 32'd56, 32'h0, rd, er, lat, rc);
      check_eq("cycle_after_reset", rd, 32'd2);
      check_eq("cycle_after_reset_err", 32'(er), 32'd0);

      txn(0, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, rd, er, lat, rc);
      check_eq("st100_lat", 32'(lat), 32'd2);
      check_eq("st100_rdata", rd, 32'd0);
      check_eq("st100_err", 32'(er), 32'd0);
      txn(0, 1'b0, 4'h0, 32'h100, 32'h0, rd, er, lat, rc);
      check_eq("ld100_lat", 32'(lat), 32'd2);
      check_eq("ld100_rdata", rd, 32'hDEAD_BEEF);
      check_eq("ld100_err", 32'(er), 32'd0);

      txn(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, rd, er, lat, rc);
      txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, rd, er, lat, rc);
      txn(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat, rc);
      check_eq("be_merge", rd, 32'h11BB_33DD);

      txn(0, 1'b1, 4'h0, 32'h100, 32'hFFFF_FFFF, rd, er, lat, rc);
      check_eq("be_zero_err", 32'(er), 32'd0);
      txn(0, 1'b0, 4'h0, 32'h100, 32'h0, rd, er, lat, rc);
      check_eq("be_zero_noop", rd, 32'hDEAD_BEEF);

      dut_a.mem[13] = 32'hCAFE_F00D;
      txn(0, 1'b1, 4'hF, 32'd52, 32'h0000_0001, rd, er, lat, rc);
      check_eq("toggle_st_err", 32'(er), 32'd0);
      check_eq("toggle_value", toggle_value[0], 32'h0000_0001);
      txn(0, 1'b0, 4'h0, 32'd52, 32'h0, rd, er, lat, rc);
      check_eq("toggle_ld", rd, 32'h0000_0001);
      check_eq("ram13_shadowed", dut_a.mem[13], 32'hCAFE_F00D);
      txn(0, 1'b1, 4'b0010, 32'd52, 32'h1234_AB78, rd, er, lat, rc);
      check_eq("toggle_byte", toggle_value[0], 32'h0000_AB01);

      txn(0, 1'b0, 4'h0, 32'h102, 32'h0, rd, er, lat, rc);
      check_eq("misalign_err", 32'(er), 32'd1);
      check_eq("misalign_rdata", rd, 32'd0);
      txn(0, 1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, rd, er, lat, rc);
      txn(0, 1'b1, 4'hF, 32'd4096, 32'hFFFF_FFFF, rd, er, lat, rc);
      check_eq("oob_st_err", 32'(er), 32'd1);
      txn(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat, rc);
      check_eq("word0_intact", rd, 32'h0BAD_F00D);
      txn(0, 1'b0, 4'h0, 32'd4100, 32'h0, rd, er, lat, rc);
      check_eq("oob_ld_err", 32'(er), 32'd1);
      check_eq("oob_ld_rdata", rd, 32'd0);
      txn(0, 1'b1, 4'hF, 32'd4092, 32'h1357_2468, rd, er, lat, rc);
      txn(0, 1'b0, 4'h0, 32'd4092, 32'h0, rd, er, lat, rc);
      check_eq("last_word", rd, 32'h1357_2468);
      check_eq("last_word_err", 32'(er), 32'd0);

      // Counter wrap: value V at release, loads commit at V+2 and V+8
      @(negedge clk);
      force dut_a.cycle_count = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut_a.cycle_count;
      txn(0, 1'b0, 4'h0, 32'd56, 32'h0, rd, er, lat, rc);
      check_eq("cycle_wrap", rd, 32'd0);
      txn(0, 1'b1, 4'hF, 32'd56, 32'h0000_0000, rd, er, lat, rc);
      check_eq("cycle_st_err", 32'(er), 32'd1);
      check_eq("cycle_st_rdata", rd, 32'd0);
      txn(0, 1'b0, 4'h0, 32'd56, 32'h0, rd, er, lat, rc);
      check_eq("cycle_undisturbed", rd, 32'd6);

      txn(1, 1'b1, 4'hF, 32'h8, 32'h0102_0304, rd, er, lat, rc_prev);
      check_eq("ws0_st_lat", 32'(lat), 32'd1);
      txn(1, 1'b0, 4'h0, 32'h8, 32'h0, rd, er, lat, rc);
      check_eq("ws0_ld_lat", 32'(lat), 32'd1);
      check_eq("ws0_ld_rdata", rd, 32'h0102_0304);
      check_eq("ws0_period", 32'(rc - rc_prev), 32'd2);

      txn(2, 1'b1, 4'hF, 32'h4, 32'h0F0F_0F0F, rd, er, lat, rc);
      check_eq("ws7_st_lat", 32'(lat), 32'd8);
      txn(2, 1'b0, 4'h0, 32'h4, 32'h0, rd, er, lat, rc);
      check_eq("ws7_ld_lat", 32'(lat), 32'd8);
      check_eq("ws7_ld_rdata", rd, 32'h0F0F_0F0F);

      // Reset during WAIT of a store must drop it
      txn(0, 1'b1, 4'hF, 32'h40, 32'h1234_5678, rd, er, lat, rc);
      txn(0, 1'b0, 4'h0, 32'h40, 32'h0, rd, er, lat, rc);
      check_eq("pre_reset_ld", rd, 32'h1234_5678);
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_be[0]    = 4'hF;
      req_addr[0]  = 32'h40;
      req_wdata[0] = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      check_eq("midop_in_wait", 32'(req_ready[0]), 32'd0);
      reset = 1'b1;
      #1;
      check_reset_outputs("midop");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_eq("midop_no_rsp", 32'(rsp_valid[0]), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_eq("after_reset_no_rsp", 32'(rsp_valid[0]), 32'd0);
      txn(0, 1'b0, 4'h0, 32'h40, 32'h0, rd, er, lat, rc);
      check_eq("store_aborted", rd, 32'h1234_5678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
